// File: rtl/con_mon.sv
// Passive monitor for the mod-6 up/down counter bus: classifies each code as step/hold/error and recovers direction.
// Latency: one cycle from a sampled code to its registered classification.
// Backpressure: none; one code is accepted every clock.
module con_mon #(
    parameter int POS_W  = 8,
    parameter int ERR_W  = 4,
    parameter int LOCK_N = 3
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [2:0]              cnt,
    input  logic                    clr,
    output logic                    dir,
    output logic                    step,
    output logic                    hold,
    output logic                    rev,
    output logic                    err,
    output logic                    locked,
    output logic signed [POS_W-1:0] pos,
    output logic [ERR_W-1:0]        err_cnt
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    state_t     state, state_nxt;
    logic [3:0] run, run_nxt;
    logic [2:0] prev, succ, pred;
    logic       have_dir;
    logic       legal, is_hold, is_up, is_dn, is_step, is_err;

    always_comb begin
        legal   = (cnt <= 3'd5);
        succ    = (prev == 3'd5) ? 3'd0 : prev + 3'd1;
        pred    = (prev == 3'd0) ? 3'd5 : prev - 3'd1;
        is_hold = legal && (cnt == prev);
        is_up   = legal && !is_hold && (cnt == succ);
        is_dn   = legal && !is_hold && !is_up && (cnt == pred);
        is_step = is_up || is_dn;
        // Illegal codes and skips both count as errors
        is_err  = !legal || (legal && !is_hold && !is_step);
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        if (clr) begin
            state_nxt = UNLOCKED;
            run_nxt   = 4'd0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (is_err) begin
                        run_nxt = 4'd0;
                    end else if (is_step) begin
                        run_nxt = run + 4'd1;
                        if (run_nxt >= LOCK_V) state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (is_err) begin
                        state_nxt = UNLOCKED;
                        run_nxt   = 4'd0;
                    end
                end
                default: begin
                    state_nxt = UNLOCKED;
                    run_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= UNLOCKED;
            run   <= 4'd0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            prev     <= 3'd4;
            dir      <= 1'b1;
            step     <= 1'b0;
            hold     <= 1'b0;
            rev      <= 1'b0;
            err      <= 1'b0;
            pos      <= '0;
            err_cnt  <= '0;
            have_dir <= 1'b0;
        end else if (clr) begin
            prev     <= legal ? cnt : 3'd4;
            dir      <= 1'b1;
            step     <= 1'b0;
            hold     <= 1'b0;
            rev      <= 1'b0;
            err      <= 1'b0;
            pos      <= '0;
            err_cnt  <= '0;
            have_dir <= 1'b0;
        end else begin
            step <= is_step;
            hold <= is_hold;
            err  <= is_err;
            rev  <= is_step && have_dir && (is_up != dir);
            if (is_step) begin
                dir      <= is_up;
                have_dir <= 1'b1;
                pos      <= is_up ? pos + POS_W'(1) : pos - POS_W'(1);
            end
            // Skips resynchronise on the new code; illegal codes leave prev alone
            if (legal && !is_hold) prev <= cnt;
            if (is_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_con_mon.sv
// Randomised and directed bench for con_mon against a behavioural model of the counter-bus rules.
module tb_con_mon;

    localparam int POS_W  = 8;
    localparam int ERR_W  = 4;
    localparam int LOCK_N = 3;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk;
    logic             res;
    logic [2:0]       cnt;
    logic             clr;
    logic             dir, step, hold, rev, err, locked;
    logic signed [POS_W-1:0] pos;
    logic [ERR_W-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int m_prev, m_dir, m_step, m_hold, m_rev, m_err, m_locked, m_pos, m_errc, m_run, m_have;

    con_mon #(.POS_W(POS_W), .ERR_W(ERR_W), .LOCK_N(LOCK_N)) dut (
        .clk     (clk),
        .res     (res),
        .cnt     (cnt),
        .clr     (clr),
        .dir     (dir),
        .step    (step),
        .hold    (hold),
        .rev     (rev),
        .err     (err),
        .locked  (locked),
        .pos     (pos),
        .err_cnt (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_prev = 4; m_dir = 1; m_step = 0; m_hold = 0; m_rev = 0; m_err = 0;
        m_locked = 0; m_pos = 0; m_errc = 0; m_run = 0; m_have = 0;
    endtask

    task automatic m_clock(input int c, input int cl);
        int d;
        int nd;
        m_step = 0; m_hold = 0; m_rev = 0; m_err = 0;
        if (cl != 0) begin
            m_locked = 0; m_run = 0; m_pos = 0; m_errc = 0; m_have = 0; m_dir = 1;
            m_prev = (c < 6) ? c : 4;
            return;
        end
        if (c > 5) begin
            m_err = 1;
        end else if (c == m_prev) begin
            m_hold = 1;
        end else begin
            d = (c + 6 - m_prev) % 6;
            if (d == 1 || d == 5) begin
                nd = (d == 1) ? 1 : 0;
                m_step = 1;
                m_rev = (m_have != 0 && nd != m_dir) ? 1 : 0;
                m_dir = nd;
                m_have = 1;
                m_pos = (m_pos + (nd != 0 ? 1 : -1)) & ((1 << POS_W) - 1);
            end else begin
                m_err = 1;
            end
            m_prev = c;
        end
        if (m_err != 0) begin
            if (m_errc < ERR_MAX) m_errc++;
            m_locked = 0;
            m_run = 0;
        end else if (m_step != 0 && m_locked == 0) begin
            m_run++;
            if (m_run >= LOCK_N) m_locked = 1;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge res);
            if (!res) m_reset();
            else m_clock(int'(cnt), int'(clr));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("dir",     int'(dir),     m_dir);
            chk("step",    int'(step),    m_step);
            chk("hold",    int'(hold),    m_hold);
            chk("rev",     int'(rev),     m_rev);
            chk("err",     int'(err),     m_err);
            chk("locked",  int'(locked),  m_locked);
            chk("pos",     int'($unsigned(pos)), m_pos);
            chk("err_cnt", int'(err_cnt), m_errc);
        end
    end

    task automatic apply(input int c, input logic cl);
        cnt = 3'(c);
        clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int r;
        res = 1'b0;
        cnt = 3'd4;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b1;

        // holds on the reset code
        for (int i = 0; i < 5; i++) begin
            apply(4, 1'b0);
            chk("t1_hold", int'(hold), 1);
            chk("t1_step", int'(step), 0);
            chk("t1_locked", int'(locked), 0);
        end
        chk("t1_pos", int'($unsigned(pos)), 0);
        chk("t1_dir", int'(dir), 1);

        // up run, lock on third step, 130 steps total
        apply(5, 1'b0);
        chk("t2_step1", int'(step), 1);
        apply(0, 1'b0);
        chk("t2_lock2", int'(locked), 0);
        apply(1, 1'b0);
        chk("t2_lock3", int'(locked), 1);
        apply(2, 1'b0);
        chk("t2_pos4", int'($unsigned(pos)), 4);
        chk("t2_dir", int'(dir), 1);
        c = 2;
        for (int i = 4; i < 130; i++) begin
            c = (c + 1) % 6;
            apply(c, 1'b0);
        end
        chk("t2_pos130", int'($unsigned(pos)), 'h82);

        // reversal while locked, 0 to 5 is down
        apply(1, 1'b0);
        chk("t3_rev1", int'(rev), 1);
        chk("t3_dir", int'(dir), 0);
        apply(0, 1'b0);
        chk("t3_rev0", int'(rev), 0);
        apply(5, 1'b0);
        chk("t3_rev5", int'(rev), 0);
        chk("t3_step5", int'(step), 1);
        chk("t3_locked", int'(locked), 1);
        chk("t3_pos", int'($unsigned(pos)), 'h7f);

        // illegal code while locked, prev held
        apply(0, 1'b0);
        apply(1, 1'b0);
        apply(2, 1'b0);
        apply(6, 1'b0);
        chk("t4_err", int'(err), 1);
        chk("t4_errcnt", int'(err_cnt), 1);
        chk("t4_locked", int'(locked), 0);
        apply(3, 1'b0);
        chk("t4_step", int'(step), 1);
        chk("t4_dir", int'(dir), 1);
        apply(4, 1'b0);
        chk("t4_run2", int'(locked), 0);
        apply(5, 1'b0);
        chk("t4_run3", int'(locked), 1);

        // skip resync and error saturation
        apply(0, 1'b0);
        apply(1, 1'b0);
        apply(3, 1'b0);
        chk("t5_skip_err", int'(err), 1);
        apply(4, 1'b0);
        chk("t5_resync_step", int'(step), 1);
        for (int i = 0; i < 20; i++) begin
            apply((i % 2 == 0) ? 0 : 3, 1'b0);
            chk("t5_alt_err", int'(err), 1);
        end
        chk("t5_sat", int'(err_cnt), 15);

        // asynchronous reset mid-lock
        apply(4, 1'b0);
        apply(5, 1'b0);
        apply(0, 1'b0);
        chk("t6_locked", int'(locked), 1);
        #2;
        res = 1'b0;
        cnt = 3'd4;
        #1;
        chk("t6_rst_locked", int'(locked), 0);
        chk("t6_rst_pos", int'($unsigned(pos)), 0);
        chk("t6_rst_errcnt", int'(err_cnt), 0);
        chk("t6_rst_dir", int'(dir), 1);
        chk("t6_rst_step", int'(step), 0);
        @(posedge clk);
        #1;
        res = 1'b1;

        // clr with an illegal code
        apply(5, 1'b0);
        apply(0, 1'b0);
        apply(2, 1'b0);
        apply(7, 1'b1);
        chk("t6_clr_err", int'(err), 0);
        chk("t6_clr_errcnt", int'(err_cnt), 0);
        chk("t6_clr_pos", int'($unsigned(pos)), 0);
        chk("t6_clr_dir", int'(dir), 1);
        apply(5, 1'b0);
        chk("t6_prev4_step", int'(step), 1);
        chk("t6_prev4_pos", int'($unsigned(pos)), 1);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                res = 1'b0;
                @(posedge clk);
                #1;
                res = 1'b1;
            end
            r = $urandom_range(0, 99);
            if (r < 40)      c = (m_prev + 1) % 6;
            else if (r < 70) c = (m_prev + 5) % 6;
            else if (r < 80) c = m_prev;
            else if (r < 90) c = 6 + $urandom_range(0, 1);
            else             c = $urandom_range(0, 5);
            apply(c, ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end
        clr = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
